// File: rtl/sync_nff.sv
// rtl/sync_nff.sv - N-flop synchroniser for a single asynchronous level input.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[N-2:0], d_i};
    end
  end

  assign q_o = s_q[N-1];

endmodule

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-link receiver: sync, edge detect, pulse and saturating pending count.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  output logic             pulse_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             tog_sync;
  logic             d_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic             pop;

  sync_nff #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (tog_in),
    .q_o   (tog_sync)
  );

  // d starts at 0 like the sender's TFF, so a high line at release is one event
  assign evt = tog_sync ^ d_q;
  assign pop = (cnt_q != '0) && evt_ready;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (evt && !pop) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!evt && pop) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q     <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      d_q     <= tog_sync;
      pulse_q <= evt;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_out = pulse_q;
  assign evt_count = cnt_q;
  assign evt_valid = (cnt_q != '0);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - self-checking bench for toggle_event_rx with a pulse scoreboard.
module tb_toggle_event_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tog_in = 1'b0;
  logic       pulse_out;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [3:0] evt_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  toggle_event_rx #(
    .SYNC_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tog_in   (tog_in),
    .pulse_out(pulse_out),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse scoreboard: every toggle pushes the negedge cycle where its pulse must appear
  always @(negedge clk) begin
    if (reset) begin
      if (pulse_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: pulse_out=1 at cycle %0d, required no pulse", cyc);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e !== cyc) begin
            errors++;
            $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        int e;
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL pulse_missing: pulse_out=0 at cycle %0d, required 1 at cycle %0d", cyc, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    tog_in = ~tog_in;
    exp_q.push_back(cyc + 3);
  endtask

  task automatic check_out(input string name, input int cnt, input logic vld, input logic ovf);
    checks++;
    if (evt_count !== 4'(cnt) || evt_valid !== vld || overflow !== ovf) begin
      errors++;
      $display("FAIL %s: count=%0d valid=%b ovf=%b, required count=%0d valid=%b ovf=%b",
               name, evt_count, evt_valid, overflow, cnt, vld, ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tog_in = 1'b0;
    tick(3);
    checks++;
    if (pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: pulse_out=%b, required 0", pulse_out);
    end
    check_out("reset_state", 0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(10);
    check_out("idle_after_release", 0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    toggle();
    tick(3);
    check_out("single_event", 1, 1'b1, 1'b0);
    tick(2);
    check_out("single_hold", 1, 1'b1, 1'b0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check_out("single_pop", 0, 1'b0, 1'b0);
  endtask

  task automatic test_three_and_drain();
    for (int i = 0; i < 3; i++) begin
      toggle();
      tick(4);
    end
    check_out("three_events", 3, 1'b1, 1'b0);
    evt_ready = 1'b1;
    tick(1);
    check_out("drain_2", 2, 1'b1, 1'b0);
    tick(1);
    check_out("drain_1", 1, 1'b1, 1'b0);
    tick(1);
    check_out("drain_0", 0, 1'b0, 1'b0);
    tick(2);
    check_out("no_underflow", 0, 1'b0, 1'b0);
    evt_ready = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 17; i++) begin
      toggle();
      tick(3);
      if (i == 15) check_out("sat_15", 15, 1'b1, 1'b0);
      if (i == 16) check_out("sat_overflow", 15, 1'b1, 1'b1);
    end
    tick(2);
    check_out("sat_17", 15, 1'b1, 1'b1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check_out("clr_ovf", 15, 1'b1, 1'b0);
  endtask

  task automatic test_pop_at_max();
    toggle();
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check_out("pop_and_evt_at_max", 15, 1'b1, 1'b0);
    tick(2);
    check_out("pop_and_evt_hold", 15, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b1;
    tick(10);
    evt_ready = 1'b0;
    check_out("pre_reset_count", 5, 1'b1, 1'b0);
    toggle();
    tick(1);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pulse: pulse_out=%b, required 0", pulse_out);
    end
    check_out("mid_reset_async", 0, 1'b0, 1'b0);
    tog_in = 1'b1;
    tick(3);
    reset = 1'b1;
    exp_q.push_back(cyc + 3);
    tick(4);
    check_out("release_high_one_event", 1, 1'b1, 1'b0);
    tick(6);
    check_out("release_exactly_one", 1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_and_drain();
    test_saturate();
    test_pop_at_max();
    test_reset_mid();
    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_outstanding: %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
